// File: rtl/mc_control.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback for the datapath,
// handshakes shared instruction/data memory with a timeout, and counts retired instructions.
module mc_control #(
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 8,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          opcode,
  input  logic                alu_zero,
  input  logic                mem_ack,
  output logic [2:0]          alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                pc_src,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                iord,
  output logic                mem_req,
  output logic                mem_we,
  output logic                halted,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  localparam logic [2:0]       OP_ADD    = 3'b010;
  localparam logic [2:0]       OP_SUB    = 3'b011;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [RETIRE_W-1:0]   retired_q, retired_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;

  logic is_ld, is_st, is_beq, is_jmp, is_mem_op;

  assign is_ld     = (opcode == 4'h7);
  assign is_st     = (opcode == 4'h8);
  assign is_beq    = (opcode == 4'h9);
  assign is_jmp    = (opcode == 4'hA);
  assign is_mem_op = is_ld | is_st;

  // The timeout counter defaults to zero so it clears whenever a waiting state is entered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    retired_d = retired_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH, S_MEM: begin
        if (mem_ack) begin
          if (state_q == S_FETCH) begin
            state_d = S_DECODE;
          end else if (is_st) begin
            state_d   = S_FETCH;
            retired_d = retired_q + RETIRE_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == TIMEOUT_C) begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (opcode == 4'hF) begin
          state_d   = S_HALT;
          halted_d  = 1'b1;
          retired_d = retired_q + RETIRE_W'(1);
        end else if (opcode > 4'hA) begin
          state_d   = S_ERR;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mem_op) begin
          state_d = S_MEM;
        end else if (is_beq || is_jmp) begin
          state_d   = S_FETCH;
          retired_d = retired_q + RETIRE_W'(1);
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + RETIRE_W'(1);
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Control outputs are gated by reset so an in-flight memory request is dropped at once.
  always_comb begin
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = OP_ADD;
          end
        end
        S_EXEC: begin
          if (is_mem_op) begin
            alu_op    = OP_ADD;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
          end else if (is_beq) begin
            alu_op    = OP_SUB;
            alu_src_a = 1'b1;
            pc_src    = 1'b1;
            pc_write  = alu_zero;
          end else if (is_jmp) begin
            pc_src   = 1'b1;
            pc_write = 1'b1;
          end else begin
            alu_op    = opcode[2:0];
            alu_src_a = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_st;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_ld;
        end
        default: ;
      endcase
    end
  end

  assign halted  = halted_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control: walks each instruction class, the memory timeout
// boundary, sticky halt/illegal states and asynchronous reset against hand-computed controls.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        alu_zero;
  logic        mem_ack;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_src, pc_write, ir_write, reg_write, mem_to_reg, iord, mem_req, mem_we;
  logic        halted, illegal;
  logic [31:0] retired;

  int vectors;
  int miscompares;

  mc_control #(.TIMEOUT(4), .CNT_W(8), .RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .iord(iord), .mem_req(mem_req), .mem_we(mem_we), .halted(halted), .illegal(illegal),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Control bundle: {alu_op, src_a, src_b, pc_src, pc_write, ir_write, reg_write, mem_to_reg, iord, mem_req, mem_we}
  logic [13:0] ctl;
  assign ctl = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, reg_write,
                mem_to_reg, iord, mem_req, mem_we};

  function automatic logic [13:0] ctl_of(input logic [2:0] op, input logic sa, input logic [1:0] sb,
                                         input logic ps, input logic pw, input logic iw,
                                         input logic rw, input logic mtr, input logic io,
                                         input logic mr, input logic mw);
    return {op, sa, sb, ps, pw, iw, rw, mtr, io, mr, mw};
  endfunction

  logic [13:0] idle_c, fetch_wait_c, fetch_ack_c, exec_mem_c, mem_ld_c, mem_st_c;
  initial begin
    idle_c       = ctl_of(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    fetch_wait_c = ctl_of(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
    fetch_ack_c  = ctl_of(3'b010, 0, 2'b01, 0, 1, 1, 0, 0, 0, 1, 0);
    exec_mem_c   = ctl_of(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_ld_c     = ctl_of(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0);
    mem_st_c     = ctl_of(3'b000, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    mem_ack = 1'b0;
    alu_zero = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Fetch with immediate ack and pass through decode; leaves the FSM just entered EXEC (or HALT/ERR).
  task automatic fetch_decode(input logic [3:0] op, input string name);
    opcode = op;
    mem_ack = 1'b1;
    #1;
    vectors++;
    if (ctl !== fetch_ack_c) begin
      miscompares++;
      $display("[TB] FAIL %s_fetch ctl got %b want %b", name, ctl, fetch_ack_c);
    end
    step();
    mem_ack = 1'b0;
    #1;
    vectors++;
    if (ctl !== idle_c) begin
      miscompares++;
      $display("[TB] FAIL %s_decode ctl got %b want %b", name, ctl, idle_c);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ack = 1'b0;
    alu_zero = 1'b0;
    opcode = 4'h0;
    #2;
    vectors++;
    if ({ctl, halted, illegal, retired} !== {idle_c, 1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL reset_state got ctl=%b h=%b i=%b r=%0d want ctl=%b 0 0 0",
               ctl, halted, illegal, retired, idle_c);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (ctl !== fetch_wait_c) begin
      miscompares++;
      $display("[TB] FAIL reset_release ctl got %b want %b", ctl, fetch_wait_c);
    end
  endtask

  task automatic test_add();
    logic [13:0] exp;
    fetch_decode(4'h2, "add");
    #1;
    exp = ctl_of(3'b010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ctl !== exp) begin
      miscompares++;
      $display("[TB] FAIL add_exec ctl got %b want %b", ctl, exp);
    end
    step();
    #1;
    exp = ctl_of(3'b000, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0);
    vectors++;
    if (ctl !== exp) begin
      miscompares++;
      $display("[TB] FAIL add_wb ctl got %b want %b", ctl, exp);
    end
    step();
    #1;
    vectors++;
    if ({ctl, retired} !== {fetch_wait_c, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL add_retire got ctl=%b r=%0d want ctl=%b r=1", ctl, retired, fetch_wait_c);
    end
  endtask

  task automatic test_ld_wait();
    logic [13:0] exp;
    fetch_decode(4'h7, "ld");
    #1;
    vectors++;
    if (ctl !== exec_mem_c) begin
      miscompares++;
      $display("[TB] FAIL ld_exec ctl got %b want %b", ctl, exec_mem_c);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      #1;
      vectors++;
      if (ctl !== mem_ld_c) begin
        miscompares++;
        $display("[TB] FAIL ld_mem_cycle%0d ctl got %b want %b", i, ctl, mem_ld_c);
      end
      if (i < 3) step();
    end
    step();
    mem_ack = 1'b0;
    #1;
    exp = ctl_of(3'b000, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0);
    vectors++;
    if (ctl !== exp) begin
      miscompares++;
      $display("[TB] FAIL ld_wb ctl got %b want %b", ctl, exp);
    end
    step();
    #1;
    vectors++;
    if ({ctl, retired} !== {fetch_wait_c, 32'd2}) begin
      miscompares++;
      $display("[TB] FAIL ld_retire got ctl=%b r=%0d want ctl=%b r=2", ctl, retired, fetch_wait_c);
    end
  endtask

  task automatic test_st();
    fetch_decode(4'h8, "st");
    #1;
    vectors++;
    if (ctl !== exec_mem_c) begin
      miscompares++;
      $display("[TB] FAIL st_exec ctl got %b want %b", ctl, exec_mem_c);
    end
    step();
    mem_ack = 1'b1;
    #1;
    vectors++;
    if (ctl !== mem_st_c) begin
      miscompares++;
      $display("[TB] FAIL st_mem ctl got %b want %b", ctl, mem_st_c);
    end
    step();
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({ctl, retired} !== {fetch_wait_c, 32'd3}) begin
      miscompares++;
      $display("[TB] FAIL st_retire got ctl=%b r=%0d want ctl=%b r=3", ctl, retired, fetch_wait_c);
    end
  endtask

  task automatic test_branch(input logic [3:0] op, input logic zero, input logic [13:0] exp,
                             input logic [31:0] exp_ret, input string name);
    fetch_decode(op, name);
    alu_zero = zero;
    #1;
    vectors++;
    if (ctl !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s_exec ctl got %b want %b", name, ctl, exp);
    end
    step();
    alu_zero = 1'b0;
    #1;
    vectors++;
    if ({ctl, retired} !== {fetch_wait_c, exp_ret}) begin
      miscompares++;
      $display("[TB] FAIL %s_retire got ctl=%b r=%0d want ctl=%b r=%0d",
               name, ctl, retired, fetch_wait_c, exp_ret);
    end
  endtask

  task automatic test_timeout_ack_wins();
    logic [13:0] exp;
    opcode = 4'h0;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 4);
      #1;
      exp = (i == 4) ? fetch_ack_c : fetch_wait_c;
      vectors++;
      if (ctl !== exp) begin
        miscompares++;
        $display("[TB] FAIL ackwin_fetch_cycle%0d ctl got %b want %b", i, ctl, exp);
      end
      if (i < 4) step();
    end
    step();
    mem_ack = 1'b0;
    #1;
    vectors++;
    if ({ctl, illegal} !== {idle_c, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL ackwin_decode got ctl=%b ill=%b want ctl=%b ill=0", ctl, illegal, idle_c);
    end
    step();
    #1;
    exp = ctl_of(3'b000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (ctl !== exp) begin
      miscompares++;
      $display("[TB] FAIL mov_exec ctl got %b want %b", ctl, exp);
    end
    step();
    step();
    #1;
    vectors++;
    if ({ctl, retired} !== {fetch_wait_c, 32'd7}) begin
      miscompares++;
      $display("[TB] FAIL mov_retire got ctl=%b r=%0d want ctl=%b r=7", ctl, retired, fetch_wait_c);
    end
  endtask

  task automatic test_reset_mid_mem();
    fetch_decode(4'h7, "rstmem");
    step();
    #1;
    vectors++;
    if (ctl !== mem_ld_c) begin
      miscompares++;
      $display("[TB] FAIL rstmem_in_mem ctl got %b want %b", ctl, mem_ld_c);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ctl, retired} !== {idle_c, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL rstmem_drop got ctl=%b r=%0d want ctl=%b r=0", ctl, retired, idle_c);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (ctl !== fetch_wait_c) begin
      miscompares++;
      $display("[TB] FAIL rstmem_release ctl got %b want %b", ctl, fetch_wait_c);
    end
  endtask

  task automatic test_illegal();
    fetch_decode(4'hC, "illop");
    for (int i = 0; i < 3; i++) begin
      mem_ack = i[0];
      #1;
      vectors++;
      if ({ctl, illegal, halted} !== {idle_c, 1'b1, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL illop_err%0d got ctl=%b ill=%b h=%b want ctl=%b ill=1 h=0",
                 i, ctl, illegal, halted, idle_c);
      end
      step();
    end
    apply_reset();
  endtask

  task automatic test_timeout_err();
    apply_reset();
    opcode = 4'h0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if ({ctl, illegal} !== {fetch_wait_c, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL timeout_req%0d got ctl=%b ill=%b want ctl=%b ill=0",
                 i, ctl, illegal, fetch_wait_c);
      end
      step();
    end
    #1;
    vectors++;
    if ({ctl, illegal} !== {idle_c, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL timeout_err got ctl=%b ill=%b want ctl=%b ill=1", ctl, illegal, idle_c);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    fetch_decode(4'hF, "halt");
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'b1;
      #1;
      vectors++;
      if ({ctl, halted, illegal, retired} !== {idle_c, 1'b1, 1'b0, 32'd1}) begin
        miscompares++;
        $display("[TB] FAIL halt_sticky%0d got ctl=%b h=%b ill=%b r=%0d want ctl=%b h=1 ill=0 r=1",
                 i, ctl, halted, illegal, retired, idle_c);
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_add();
    test_ld_wait();
    test_st();
    test_branch(4'h9, 1'b1, ctl_of(3'b011, 1, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0), 32'd4, "beq_taken");
    test_branch(4'h9, 1'b0, ctl_of(3'b011, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0), 32'd5, "beq_not");
    test_branch(4'hA, 1'b0, ctl_of(3'b000, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0), 32'd6, "jmp");
    test_timeout_ack_wins();
    test_reset_mid_mem();
    test_illegal();
    test_timeout_err();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
